// File: rtl/store_merge_unit.sv
// -----------------------------------------------------------------------------
// store_merge_unit
//
// Purpose
//   Store path between the EX/MEM stage and a word-wide data memory that has no
//   byte enables. Word stores are written straight through. Byte and halfword
//   stores are done as read-modify-write: read the word, merge the new lane(s),
//   then write the whole word back. Little-endian lane numbering.
//
// Parameters
//   ADDR_W       byte-address width
//   RD_LAT       memory read latency in cycles (>= 1); mem_rd_o is held this long
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active-high
//   req_i        store request, accepted only while idle (busy_o = 0)
//   size_i       00 byte, 01 halfword, 10 word, 11 treated as word
//   addr_i       byte address of the store
//   wdata_i      right-justified store data
//   busy_o       high from the cycle after acceptance until idle again
//   done_o       one-cycle completion pulse
//   err_o        one-cycle pulse with done_o for a rejected (misaligned) store
//   mem_addr_o   word address to memory, low two bits always 0
//   mem_rd_o     memory read strobe
//   mem_rdata_i  memory read data
//   mem_we_o     memory write strobe, one cycle per store
//   mem_wdata_o  full word written
//
// Build option
//   STORE_MISALIGN_TRAP_EN
//     defined   : misaligned half/word stores skip memory and finish with err_o.
//     undefined : err_o is tied 0; offending low address bits are cleared and
//                 the store proceeds at the aligned location.
//
// FSM states
//   state   | meaning
//   IDLE    | waiting for req_i, request fields latched on acceptance
//   READ    | mem_rd_o asserted for RD_LAT cycles, merge captured on last edge
//   WRITE   | mem_we_o asserted with the merged (or full) word
//   DONE    | done_o pulse (and err_o for a trapped store), back to IDLE
// -----------------------------------------------------------------------------
module store_merge_unit #(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic [1:0]        size_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              mem_we_o,
  output logic [31:0]       mem_wdata_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  // Read-wait down-counter: loaded with RD_LAT-1 on entry to READ, the merge
  // is captured on the edge where it reads zero.
  localparam int              CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_lane;
  logic              r_half;
  logic [15:0]       r_sdata;
  logic [31:0]       r_wdata;

  logic              w_is_word;
  logic              w_is_half;
  logic [1:0]        w_lane;
  logic [ADDR_W-1:0] w_req_addr;
  logic              w_trap;
  logic [31:0]       w_merged;

  // Request decode. Size 11 is handled as a word store.
  assign w_is_word  = size_i[1];
  assign w_is_half  = (size_i == SZ_HALF);
  assign w_req_addr = {addr_i[ADDR_W-1:2], 2'b00};

  // Lane select with alignment forced: a halfword always starts on an even
  // byte, a word always on lane 0. In the trapping build the forced value is
  // never used for a misaligned request because it never reaches memory.
  always_comb begin
    w_lane = 2'b00;
    if (size_i == SZ_BYTE) begin
      w_lane = addr_i[1:0];
    end else if (w_is_half) begin
      w_lane = {addr_i[1], 1'b0};
    end
  end

`ifdef STORE_MISALIGN_TRAP_EN
  logic w_misalign;
  logic r_err;

  assign w_misalign = (w_is_half & addr_i[0]) | (w_is_word & (addr_i[1:0] != 2'b00));
  assign w_trap     = w_misalign;
  assign err_o      = r_err;

  // r_err is set only on the IDLE->DONE trap transition and cleared when DONE
  // is left, so it is high for exactly the DONE cycle of a trapped store.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_err <= req_i & w_misalign;
    end else if (r_state == S_DONE) begin
      r_err <= 1'b0;
    end
  end
`else
  assign w_trap = 1'b0;
  assign err_o  = 1'b0;
`endif

  // Merge the latched store lane(s) into the word being read back.
  always_comb begin
    w_merged = mem_rdata_i;
    if (r_half) begin
      w_merged[{r_lane[1], 4'b0000} +: 16] = r_sdata;
    end else begin
      w_merged[{r_lane, 3'b000} +: 8] = r_sdata[7:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_lane  <= 2'b00;
      r_half  <= 1'b0;
      r_sdata <= 16'h0000;
      r_wdata <= 32'h0000_0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_i) begin
            r_addr  <= w_req_addr;
            r_lane  <= w_lane;
            r_half  <= w_is_half;
            r_sdata <= wdata_i[15:0];
            if (w_trap) begin
              r_state <= S_DONE;
            end else if (w_is_word) begin
              r_wdata <= wdata_i;
              r_state <= S_WRITE;
            end else begin
              r_cnt   <= CNT_LOAD;
              r_state <= S_READ;
            end
          end
        end
        S_READ: begin
          if (r_cnt == '0) begin
            r_wdata <= w_merged;
            r_state <= S_WRITE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_WRITE: begin
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Strobes decode straight from the state register, so they are mutually
  // exclusive and drop together with the state on reset.
  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = (r_state == S_DONE);
  assign mem_rd_o    = (r_state == S_READ);
  assign mem_we_o    = (r_state == S_WRITE);
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;

endmodule
